// File: rtl/player_motion_ctrl_if.sv
// Bus between a player controller and the game logic: keyboard slots and
// collider bounds flow in, position and animation information flows out.
interface player_motion_ctrl_if #(
    parameter int NUM_KEYS = 2
);
    logic [8*NUM_KEYS-1:0] keycodes;
    logic [9:0]            X_Min;
    logic [9:0]            X_Max;
    logic [9:0]            Y_Min;
    logic [9:0]            Y_Max;
    logic [9:0]            pos_x;
    logic [9:0]            pos_y;
    logic                  facing_left;
    logic                  grounded;
    logic [1:0]            anim_state;
    logic [2:0]            frame_index;
    logic                  tick;

    modport master (
        output keycodes, X_Min, X_Max, Y_Min, Y_Max,
        input  pos_x, pos_y, facing_left, grounded, anim_state, frame_index, tick
    );

    modport slave (
        input  keycodes, X_Min, X_Max, Y_Min, Y_Max,
        output pos_x, pos_y, facing_left, grounded, anim_state, frame_index, tick
    );
endinterface

// File: rtl/player_motion_ctrl.sv
// Per-character movement controller: keys -> motion, jump, gravity, bound clamping, animation.
// Define PLAYER_COYOTE_EN to allow a short jump grace window after leaving the ground.
module player_motion_ctrl #(
    parameter int         W           = 32,
    parameter int         H           = 48,
    parameter int         START_X     = 32,
    parameter int         START_Y     = 416,
    parameter int         VX          = 2,
    parameter int         JUMP_V0     = 7,
    parameter int         GRAVITY     = 1,
    parameter int         GRAV_DIV    = 4,
    parameter int         VY_MAX      = 6,
    parameter int         ANIM_DIV    = 4,
    parameter int         IDLE_FRAMES = 4,
    parameter int         RUN_FRAMES  = 4,
    parameter int         AIR_FRAMES  = 1,
    parameter int         NUM_KEYS    = 2,
    parameter logic [7:0] KEY_LEFT    = 8'h04,
    parameter logic [7:0] KEY_RIGHT   = 8'h07,
    parameter logic [7:0] KEY_JUMP    = 8'h1a
) (
    input  logic                 Clk,
    input  logic                 revive_n,
    input  logic                 frame_clk,
    player_motion_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ANIM_IDLE = 2'd0,
        ANIM_RUN  = 2'd1,
        ANIM_JUMP = 2'd2,
        ANIM_FALL = 2'd3
    } anim_e;

    localparam int GCW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    localparam int ACW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic signed [11:0] W_S  = 12'(W);
    localparam logic signed [11:0] H_S  = 12'(H);
    localparam logic signed [11:0] VX_S = 12'(VX);

    logic [2:0]            fsync_q;
    logic                  frame_rise;
    logic [9:0]            x_q, x_d, y_q, y_d;
    logic signed [7:0]     vy_q, vy_d;
    logic                  facing_q, facing_d;
    logic                  grounded_q, grounded_d;
    anim_e                 anim_q, anim_d;
    logic [2:0]            frame_q, frame_d;
    logic [GCW-1:0]        grav_cnt_q, grav_cnt_d;
    logic [ACW-1:0]        anim_cnt_q, anim_cnt_d;
    logic                  tick_q;
`ifdef PLAYER_COYOTE_EN
    logic [2:0]            coyote_q, coyote_d;
`endif

    logic                  key_left, key_right, key_jump, moving, jump_ok;
    logic signed [11:0]    vx, nx, ny;
    logic signed [7:0]     vy_g, vy_sum;

    // fsync_q[0..1] form the synchronizer, fsync_q[2] holds the previous synced level
    assign frame_rise = fsync_q[1] & ~fsync_q[2];

    function automatic logic [3:0] frames_of(input anim_e s);
        case (s)
            ANIM_IDLE: frames_of = 4'(IDLE_FRAMES);
            ANIM_RUN:  frames_of = 4'(RUN_FRAMES);
            default:   frames_of = 4'(AIR_FRAMES);
        endcase
    endfunction

    always_comb begin
        key_left  = 1'b0;
        key_right = 1'b0;
        key_jump  = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (bus.keycodes[8*k +: 8] == KEY_LEFT)  key_left  = 1'b1;
            if (bus.keycodes[8*k +: 8] == KEY_RIGHT) key_right = 1'b1;
            if (bus.keycodes[8*k +: 8] == KEY_JUMP)  key_jump  = 1'b1;
        end
        moving = key_left ^ key_right;
        vx     = '0;
        if (moving) vx = key_left ? -VX_S : VX_S;
    end

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        vy_d       = vy_q;
        facing_d   = facing_q;
        grounded_d = grounded_q;
        anim_d     = anim_q;
        frame_d    = frame_q;
        grav_cnt_d = grav_cnt_q;
        anim_cnt_d = anim_cnt_q;
        vy_sum     = vy_q + 8'(GRAVITY);
        vy_g       = vy_q;
        jump_ok    = 1'b0;
        nx         = '0;
        ny         = '0;
`ifdef PLAYER_COYOTE_EN
        coyote_d   = coyote_q;
`endif
        if (frame_rise) begin
            if (grav_cnt_q == GCW'(GRAV_DIV - 1)) begin
                grav_cnt_d = '0;
                vy_g       = (vy_sum > 8'(VY_MAX)) ? 8'(VY_MAX) : vy_sum;
            end else begin
                grav_cnt_d = grav_cnt_q + GCW'(1);
            end
            vy_d = vy_g;
`ifdef PLAYER_COYOTE_EN
            jump_ok = key_jump && (grounded_q || (coyote_q != 3'd0 && !vy_g[7]));
`else
            jump_ok = key_jump && grounded_q;
`endif
            if (jump_ok) begin
                vy_d       = -8'(JUMP_V0);
                grav_cnt_d = '0;
                grounded_d = 1'b0;
            end
            if (moving) facing_d = key_left;

            nx = $signed({2'b00, x_q}) + vx;
            ny = $signed({2'b00, y_q}) + {{4{vy_d[7]}}, vy_d};
            if (nx < $signed({2'b00, bus.X_Min}))             x_d = bus.X_Min;
            else if (nx + W_S > $signed({2'b00, bus.X_Max}))  x_d = bus.X_Max - 10'(W);
            else                                              x_d = nx[9:0];

            // a ceiling hit kills upward speed; touching the floor counts as landing
            if (ny < $signed({2'b00, bus.Y_Min})) begin
                y_d        = bus.Y_Min;
                vy_d       = '0;
                grounded_d = 1'b0;
            end else if (ny + H_S >= $signed({2'b00, bus.Y_Max})) begin
                y_d        = bus.Y_Max - 10'(H);
                vy_d       = '0;
                grounded_d = 1'b1;
            end else begin
                y_d        = ny[9:0];
                grounded_d = 1'b0;
            end
`ifdef PLAYER_COYOTE_EN
            if (jump_ok)               coyote_d = 3'd0;
            else if (grounded_d)       coyote_d = 3'd4;
            else if (coyote_q != 3'd0) coyote_d = coyote_q - 3'd1;
`endif
            if (!grounded_d) anim_d = vy_d[7] ? ANIM_JUMP : ANIM_FALL;
            else             anim_d = moving ? ANIM_RUN : ANIM_IDLE;

            if (anim_d != anim_q) begin
                frame_d    = '0;
                anim_cnt_d = '0;
            end else if (anim_cnt_q == ACW'(ANIM_DIV - 1)) begin
                anim_cnt_d = '0;
                frame_d    = ({1'b0, frame_q} + 4'd1 >= frames_of(anim_d)) ? 3'd0 : frame_q + 3'd1;
            end else begin
                anim_cnt_d = anim_cnt_q + ACW'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge revive_n) begin
        if (!revive_n) begin
            fsync_q    <= '0;
            x_q        <= 10'(START_X);
            y_q        <= 10'(START_Y);
            vy_q       <= '0;
            facing_q   <= 1'b0;
            grounded_q <= 1'b1;
            anim_q     <= ANIM_IDLE;
            frame_q    <= '0;
            grav_cnt_q <= '0;
            anim_cnt_q <= '0;
            tick_q     <= 1'b0;
`ifdef PLAYER_COYOTE_EN
            coyote_q   <= '0;
`endif
        end else begin
            fsync_q    <= {fsync_q[1:0], frame_clk};
            x_q        <= x_d;
            y_q        <= y_d;
            vy_q       <= vy_d;
            facing_q   <= facing_d;
            grounded_q <= grounded_d;
            anim_q     <= anim_d;
            frame_q    <= frame_d;
            grav_cnt_q <= grav_cnt_d;
            anim_cnt_q <= anim_cnt_d;
            tick_q     <= frame_rise;
`ifdef PLAYER_COYOTE_EN
            coyote_q   <= coyote_d;
`endif
        end
    end

    assign bus.pos_x       = x_q;
    assign bus.pos_y       = y_q;
    assign bus.facing_left = facing_q;
    assign bus.grounded    = grounded_q;
    assign bus.anim_state  = anim_q;
    assign bus.frame_index = frame_q;
    assign bus.tick        = tick_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl: each frame pulse queues its expected result,
// and a negedge monitor compares whenever the DUT raises tick.
module tb_player_motion_ctrl;

    typedef struct packed {
        logic [9:0] px;
        logic [9:0] py;
        logic       fl;
        logic       gr;
        logic [1:0] st;
        logic [2:0] fi;
    } exp_t;

    logic Clk       = 1'b0;
    logic revive_n  = 1'b0;
    logic frame_clk = 1'b0;

    player_motion_ctrl_if #(.NUM_KEYS(2)) bus ();

    player_motion_ctrl dut (
        .Clk       (Clk),
        .revive_n  (revive_n),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    always #5 Clk = ~Clk;

    exp_t  sbq[$];
    string nameq[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    always @(negedge Clk) begin
        if (revive_n && bus.tick) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_tick actual=1 expected=0");
            end else begin
                exp_t  e;
                string n;
                e = sbq.pop_front();
                n = nameq.pop_front();
                checkOutput($sformatf("%s.pos_x", n),       int'(bus.pos_x),       int'(e.px));
                checkOutput($sformatf("%s.pos_y", n),       int'(bus.pos_y),       int'(e.py));
                checkOutput($sformatf("%s.facing_left", n), int'(bus.facing_left), int'(e.fl));
                checkOutput($sformatf("%s.grounded", n),    int'(bus.grounded),    int'(e.gr));
                checkOutput($sformatf("%s.anim_state", n),  int'(bus.anim_state),  int'(e.st));
                checkOutput($sformatf("%s.frame_index", n), int'(bus.frame_index), int'(e.fi));
            end
        end
    end

    // one frame_clk pulse; also measures rise-to-tick latency in Clk cycles
    task automatic frameTick();
        int  n;
        bit  seen;
        @(negedge Clk);
        frame_clk = 1'b1;
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge Clk);
            #1;
            n++;
            if (bus.tick) seen = 1'b1;
        end
        checkOutput("tick_latency", seen ? n : 99, 3);
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic applyStimulus(input logic [15:0] keys, input string name,
                                 input int px, input int py, input int fl,
                                 input int gr, input int st, input int fi);
        exp_t e;
        e.px = 10'(px);
        e.py = 10'(py);
        e.fl = 1'(fl);
        e.gr = 1'(gr);
        e.st = 2'(st);
        e.fi = 3'(fi);
        sbq.push_back(e);
        nameq.push_back(name);
        bus.keycodes = keys;
        frameTick();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput($sformatf("%s.pos_x", tag),       int'(bus.pos_x),       32);
        checkOutput($sformatf("%s.pos_y", tag),       int'(bus.pos_y),       416);
        checkOutput($sformatf("%s.facing_left", tag), int'(bus.facing_left), 0);
        checkOutput($sformatf("%s.grounded", tag),    int'(bus.grounded),    1);
        checkOutput($sformatf("%s.anim_state", tag),  int'(bus.anim_state),  0);
        checkOutput($sformatf("%s.frame_index", tag), int'(bus.frame_index), 0);
        checkOutput($sformatf("%s.tick", tag),        int'(bus.tick),        0);
    endtask

    task automatic doReset();
        @(negedge Clk);
        revive_n     = 1'b0;
        frame_clk    = 1'b0;
        bus.keycodes = '0;
        repeat (3) @(negedge Clk);
        checkResetValues("reset");
        revive_n = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idle_f [0:19] = '{0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,0,0,0,1};
        int y, vy, gr, st, x;
        logic [15:0] ky;

        bus.keycodes = '0;
        bus.X_Min    = 10'd0;
        bus.X_Max    = 10'd640;
        bus.Y_Min    = 10'd0;
        bus.Y_Max    = 10'd464;
        doReset();

        for (int i = 0; i < 20; i++)
            applyStimulus(16'h0000, "idle", 32, 416, 0, 1, 0, idle_f[i]);

        for (int i = 0; i < 10; i++)
            applyStimulus(16'h0007, "run_right", 34 + 2*i, 416, 0, 1, 1, i/4);

        for (int i = 0; i < 3; i++)
            applyStimulus(16'h0407, "both_keys", 52, 416, 0, 1, 0, 0);

        // vy starts at -7 and rises by 1 every 4th tick, capped at 6, until the floor
        y = 416;
        for (int t = 1; t <= 61; t++) begin
            ky = (t == 1) ? 16'h001a : 16'h0000;
            vy = -7 + (t - 1) / 4;
            if (vy > 6) vy = 6;
            y = y + vy;
            if (y + 48 >= 464) begin
                y  = 416;
                gr = 1;
                st = 0;
            end else begin
                gr = 0;
                st = (vy < 0) ? 2 : 3;
            end
            applyStimulus(ky, "jump", 52, y, 0, gr, st, 0);
        end

        doReset();
        for (int t = 1; t <= 20; t++) begin
            x = 32 - 2*t;
            if (x < 0) x = 0;
            applyStimulus(16'h0004, "left_clamp", x, 416, 1, 1, 1, ((t - 1) / 4) % 4);
        end
        applyStimulus(16'h0000, "release_left", 0, 416, 1, 1, 0, 0);

        doReset();
        bus.Y_Min = 10'd405;
        applyStimulus(16'h001a, "ceiling_t1", 32, 409, 0, 0, 2, 0);
        applyStimulus(16'h0000, "ceiling_t2", 32, 405, 0, 0, 3, 0);
        applyStimulus(16'h0000, "ceiling_t3", 32, 405, 0, 0, 3, 0);
        applyStimulus(16'h0000, "ceiling_t4", 32, 405, 0, 0, 3, 0);
        applyStimulus(16'h0000, "ceiling_t5", 32, 406, 0, 0, 3, 0);
        bus.Y_Min = 10'd0;

        doReset();
        applyStimulus(16'h001a, "prejump_t1", 32, 409, 0, 0, 2, 0);
        applyStimulus(16'h0000, "prejump_t2", 32, 402, 0, 0, 2, 0);
        applyStimulus(16'h0000, "prejump_t3", 32, 395, 0, 0, 2, 0);
        @(posedge Clk);
        #3;
        revive_n = 1'b0;
        #1;
        checkResetValues("async_reset");
        repeat (2) @(negedge Clk);
        revive_n = 1'b1;
        repeat (2) @(negedge Clk);

        doReset();
        applyStimulus(16'h0000, "coyote_grounded", 32, 416, 0, 1, 0, 0);
        bus.Y_Max = 10'd600;
        applyStimulus(16'h0000, "airborne_t1", 32, 416, 0, 0, 3, 0);
        applyStimulus(16'h0000, "airborne_t2", 32, 416, 0, 0, 3, 0);
`ifdef PLAYER_COYOTE_EN
        applyStimulus(16'h001a, "coyote_jump", 32, 409, 0, 0, 2, 0);
`else
        applyStimulus(16'h001a, "late_jump_ignored", 32, 417, 0, 0, 3, 0);
`endif
        bus.Y_Max    = 10'd464;
        bus.keycodes = '0;

        checkOutput("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
